// File: rtl/pe_alu_xbar_cluster.sv
// Processing-element slice for a CGRA array.
// A 4x4 operand crossbar feeds a registered two-operand ALU.
// A 2x1 output mux selects the PE result.
// Routing and opcode are loaded through an 11-bit serial config chain that daisy-chains
// from PE to PE. Crossbar source 2 is the registered ALU result, so loop-back paths
// never form a combinational loop.
module pe_alu_xbar_cluster #(
  parameter int unsigned SIZE = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            config_en,
  input  logic            config_in,
  output logic            config_out,
  input  logic [SIZE-1:0] in0,
  input  logic [SIZE-1:0] in1,
  input  logic [SIZE-1:0] in2,
  output logic [SIZE-1:0] out0,
  output logic [SIZE-1:0] out1
);

  localparam int unsigned CfgW = 11;

  typedef enum logic [1:0] {
    OpAdd = 2'b00,
    OpSub = 2'b01,
    OpMul = 2'b10,
    OpAnd = 2'b11
  } alu_op_e;

  logic [CfgW-1:0] cfg_q, cfg_d;
  logic [SIZE-1:0] alu_q, alu_d;
  logic [SIZE-1:0] xbar [4];
  logic [SIZE-1:0] op_a, op_b;
  alu_op_e         alu_op;

  // Config chain next state: shift MSB-first while enabled, otherwise hold.
  always_comb begin
    cfg_d = cfg_q;
    if (config_en) begin
      cfg_d = {cfg_q[CfgW-2:0], config_in};
    end
  end

  // Config register; reset wins over shifting and discards a partial load.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q <= '0;
    end else begin
      cfg_q <= cfg_d;
    end
  end

  // Crossbar: each output independently picks one of in0, in1, alu_q, in2.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      xbar[k] = '0;
      unique case (cfg_q[3+2*k +: 2])
        2'd0: xbar[k] = in0;
        2'd1: xbar[k] = in1;
        2'd2: xbar[k] = alu_q;
        2'd3: xbar[k] = in2;
        default: xbar[k] = '0;
      endcase
    end
  end

  assign op_a   = xbar[0];
  assign op_b   = xbar[1];
  assign alu_op = alu_op_e'(cfg_q[1:0]);

  // ALU next-state: all results wrap modulo 2^SIZE; the product keeps only the low bits.
  always_comb begin
    alu_d = alu_q;
    if (!config_en) begin
      unique case (alu_op)
        OpAdd: alu_d = op_a + op_b;
        OpSub: alu_d = op_a - op_b;
        OpMul: alu_d = op_a * op_b;
        OpAnd: alu_d = op_a & op_b;
        default: alu_d = alu_q;
      endcase
    end
  end

  // ALU result register; it stays frozen while the config chain is shifting.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_q <= '0;
    end else begin
      alu_q <= alu_d;
    end
  end

  // Output mux and pass-through of crossbar output 3.
  always_comb begin
    out0 = cfg_q[2] ? xbar[2] : alu_q;
    out1 = xbar[3];
  end

  // Registered tap of the chain, so config_out never follows config_in combinationally.
  assign config_out = cfg_q[CfgW-1];

endmodule

// File: tb/tb_pe_alu_xbar_cluster.sv
// Self-checking bench for pe_alu_xbar_cluster.
// Directed scenarios plus a randomized run, checked against a cycle-level behavioural model.
module tb_pe_alu_xbar_cluster;

  logic        clk;
  logic        reset;
  logic        config_en;
  logic        config_in;
  logic        config_out;
  logic [31:0] in0, in1, in2;
  logic [31:0] out0, out1;

  int unsigned n_tests;
  int unsigned n_fail;

  // Behavioural model state: configuration word and ALU result.
  logic [10:0] m_cfg;
  logic [31:0] m_alu;

  pe_alu_xbar_cluster #(
    .SIZE(32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .config_en (config_en),
    .config_in (config_in),
    .config_out(config_out),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .out0      (out0),
    .out1      (out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] src_val(input int s);
    case (s)
      0:       return in0;
      1:       return in1;
      2:       return m_alu;
      default: return in2;
    endcase
  endfunction

  // Value driven on crossbar output k under the model configuration.
  function automatic logic [31:0] xb(input int k);
    int s;
    s = (int'(m_cfg) >> (3 + 2 * k)) & 3;
    return src_val(s);
  endfunction

  function automatic logic [31:0] alu_ref(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] w;
    case (op)
      0:       w = {32'b0, a} + {32'b0, b};
      1:       w = {32'b0, a} - {32'b0, b};
      2:       w = {32'b0, a} * {32'b0, b};
      default: w = {32'b0, a & b};
    endcase
    return w[31:0];
  endfunction

  function automatic logic [31:0] exp_out0();
    if (m_cfg[2]) return xb(2);
    return m_alu;
  endfunction

  task automatic check_model(input string ctx);
    check_eq({ctx, ".out0"}, out0, exp_out0());
    check_eq({ctx, ".out1"}, out1, xb(3));
    check_eq({ctx, ".cfg_out"}, {31'b0, config_out}, {31'b0, m_cfg[10]});
  endtask

  // Advance one clock: update the model from the pre-edge inputs, then compare after the edge.
  task automatic step();
    logic [10:0] n_cfg;
    logic [31:0] n_alu;
    n_cfg = m_cfg;
    n_alu = m_alu;
    if (reset) begin
      n_cfg = '0;
      n_alu = '0;
    end else if (config_en) begin
      n_cfg = {m_cfg[9:0], config_in};
    end else begin
      n_alu = alu_ref(int'(m_cfg[1:0]), xb(0), xb(1));
    end
    @(posedge clk);
    #1;
    m_cfg = n_cfg;
    m_alu = n_alu;
    check_model("step");
  endtask

  // Shift an 11-bit word MSB-first, then drop config_en.
  task automatic load_cfg(input logic [10:0] v);
    for (int i = 10; i >= 0; i--) begin
      config_en = 1'b1;
      config_in = v[i];
      step();
    end
    config_en = 1'b0;
    config_in = 1'b0;
  endtask

  logic [10:0] pat;

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    m_cfg     = '0;
    m_alu     = '0;
    reset     = 1'b1;
    config_en = 1'b0;
    config_in = 1'b0;
    in0       = 32'd5;
    in1       = 32'd0;
    in2       = 32'd0;

    // Reset: two cycles, then release.
    step();
    step();
    check_eq("rst.alu", out0, 32'd0);
    check_eq("rst.cfg_out", {31'b0, config_out}, 32'd0);
    reset = 1'b0;
    step();
    check_eq("rst.out0_2x", out0, 32'd10);
    check_eq("rst.out1_in0", out1, 32'd5);

    // Config shift: out3=1 out2=3 out1=1 out0=0 mux=0 op=sub.
    pat = 11'b01_11_01_00_0_01;
    in0 = 32'd20;
    in1 = 32'd7;
    load_cfg(pat);
    step();
    check_eq("cfg.sub", out0, 32'd13);
    check_eq("cfg.out1", out1, 32'd7);
    check_eq("cfg.tap0", {31'b0, config_out}, {31'b0, pat[10]});
    for (int k = 1; k <= 10; k++) begin
      config_en = 1'b1;
      config_in = 1'b0;
      step();
      check_eq($sformatf("cfg.tap%0d", k), {31'b0, config_out}, {31'b0, pat[10-k]});
    end
    config_en = 1'b1;
    step();
    check_eq("cfg.flushed", {31'b0, config_out}, 32'd0);
    config_en = 1'b0;

    // Opcodes with a = in0, b = in1.
    in0 = 32'hFFFF_FFFF;
    in1 = 32'd2;
    load_cfg(11'b00_00_01_00_0_00);
    step();
    check_eq("op.add_wrap", out0, 32'd1);
    load_cfg(11'b00_00_01_00_0_10);
    step();
    check_eq("op.mul_low", out0, 32'hFFFF_FFFE);
    load_cfg(11'b00_00_01_00_0_11);
    step();
    check_eq("op.and", out0, 32'd2);
    in0 = 32'd0;
    in1 = 32'd1;
    load_cfg(11'b00_00_01_00_0_01);
    step();
    check_eq("op.sub_wrap", out0, 32'hFFFF_FFFF);

    // Accumulate: clear alu_q via AND with 0, then a=alu_q, b=in2, add.
    in2 = 32'd0;
    load_cfg(11'b00_00_11_10_0_11);
    step();
    check_eq("acc.clear", out0, 32'd0);
    load_cfg(11'b00_00_11_10_0_00);
    in2 = 32'd3;
    for (int k = 1; k <= 4; k++) begin
      step();
      check_eq($sformatf("acc.%0d", k), out0, 32'(3 * k));
    end
    config_en = 1'b1;
    config_in = 1'b0;
    step();
    check_eq("acc.frozen", out0, 32'd12);
    config_en = 1'b0;

    // Bypass: mux=1, out2 sel=in2; combinational, independent of alu_q.
    load_cfg(11'b00_11_00_00_1_00);
    in2 = 32'h0000_ABCD;
    #1;
    check_eq("byp.abcd", out0, 32'h0000_ABCD);
    in2 = 32'h1234_5678;
    #1;
    check_eq("byp.change", out0, 32'h1234_5678);
    check_model("byp");

    // Reset mid-shift: five bits then reset with config_en still high.
    in0 = 32'd5;
    for (int k = 0; k < 5; k++) begin
      config_en = 1'b1;
      config_in = 1'b1;
      step();
    end
    reset = 1'b1;
    step();
    reset     = 1'b0;
    config_en = 1'b0;
    check_eq("mid.alu0", out0, 32'd0);
    check_eq("mid.out1", out1, 32'd5);
    step();
    check_eq("mid.out0_2x", out0, 32'd10);

    // Randomized run against the model.
    for (int c = 0; c < 2000; c++) begin
      in0 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      in1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      in2 = $urandom;
      config_en = ($urandom_range(0, 3) == 0);
      config_in = 1'($urandom_range(0, 1));
      reset     = ($urandom_range(0, 99) == 0);
      #1;
      check_model("rnd.comb");
      step();
    end
    reset     = 1'b0;
    config_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
